watch_ctrl_p: RTL

- Parametrised successor to the team's 1 kHz keypad digital watch.
- Keeps HH:MM:SS in BCD and multiplexes six 7-segment digits.
- Adds generic clock rate, a runtime 12/24-hour display mode, and validated keypad entry with cancel and a blinking cursor.
- Time keeps running while the user edits.
- Sits between the debounced keypad scanner and the board's 8-digit segment driver.

---
 rtl/watch_pkg.sv | 56 +++++
 rtl/seg7_decode.sv | 23 ++
 rtl/watch_ctrl_p.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared constants, types and the BCD time-increment helper for the keypad watch.
// Combinational only; nothing here carries state or flow control.
package watch_pkg;

    localparam logic [3:0] KEY_STAR       = 4'hE;
    localparam logic [3:0] KEY_HASH       = 4'hF;
    localparam logic [3:0] DIGIT_MAX      = 4'd9;
    localparam logic [3:0] BLANK          = 4'hF;
    localparam logic [3:0] H_ONE_LIMIT_20 = 4'd3;

    localparam logic [7:0] COM_OFF = 8'hFF;
    localparam logic [7:0] COM_PAT [6] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};

    // Largest legal digit per edit position, h_ten first.
    localparam logic [3:0] POS_LIMIT [6] = '{4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    typedef enum logic {ST_RUN, ST_SET} state_t;

    // Element 5 is h_ten and element 0 is s_one, so the packed value reads as HHMMSS.
    typedef logic [5:0][3:0] bcd_time_t;

    function automatic logic [2:0] pos_idx(input logic [2:0] p);
        return 3'd5 - p;
    endfunction

    function automatic bcd_time_t time_inc(input bcd_time_t t);
        bcd_time_t n = t;
        if (t[0] != 4'd9) n[0] = t[0] + 4'd1;
        else begin
            n[0] = 4'd0;
            if (t[1] != 4'd5) n[1] = t[1] + 4'd1;
            else begin
                n[1] = 4'd0;
                if (t[2] != 4'd9) n[2] = t[2] + 4'd1;
                else begin
                    n[2] = 4'd0;
                    if (t[3] != 4'd5) n[3] = t[3] + 4'd1;
                    else begin
                        n[3] = 4'd0;
                        if (t[5] == 4'd2 && t[4] == 4'd3) begin
                            n[5] = 4'd0;
                            n[4] = 4'd0;
                        end else if (t[4] == 4'd9) begin
                            n[4] = 4'd0;
                            n[5] = t[5] + 4'd1;
                        end else begin
                            n[4] = t[4] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to {a..g} segment decode, active-high; codes 10-15 are blank.
// Purely combinational, zero latency, no backpressure.
module seg7_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (bcd)
            4'd0: seg = 7'h7E;
            4'd1: seg = 7'h30;
            4'd2: seg = 7'h6D;
            4'd3: seg = 7'h79;
            4'd4: seg = 7'h33;
            4'd5: seg = 7'h5B;
            4'd6: seg = 7'h5F;
            4'd7: seg = 7'h70;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h7B;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/watch_ctrl_p.sv
// HH:MM:SS BCD watch with keypad set/cancel, 12/24h display and a 6-digit muxed 7-seg output.
// Segment outputs are registered (latency 1 from scan index); keys are strobes and are never stalled.
module watch_ctrl_p #(
    parameter int CLK_HZ       = 1000,
    parameter int SCAN_DIV     = 1,
    parameter int BLINK_DIV    = 250,
    parameter bit SEG_ACT_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_input,
    input  logic       keypad_valid,
    input  logic       mode_12h,
    output logic [7:0] seg_data,
    output logic [7:0] seg_com,
    output logic       setting,
    output logic       pm,
    output logic       sec_pulse
);
    import watch_pkg::*;

    localparam int DIV_W   = (CLK_HZ    > 1) ? $clog2(CLK_HZ)    : 1;
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [7:0] SEG_OFF = SEG_ACT_HIGH ? 8'h00 : 8'hFF;

    state_t               state, state_nxt;
    bcd_time_t            time_q, temp_q, src, disp;
    logic [2:0]           pos, scan_idx;
    logic [DIV_W-1:0]     div_q;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_on;
    logic [3:0]           lim, cur_digit;
    logic [6:0]           seg7;
    logic [7:0]           seg_raw;
    logic                 dp, blank_all, digit_ok;

    wire key_star  = keypad_valid && (keypad_input == KEY_STAR);
    wire key_hash  = keypad_valid && (keypad_input == KEY_HASH);
    wire key_digit = keypad_valid && (keypad_input <= DIGIT_MAX);
    wire tick      = (div_q == DIV_W'(CLK_HZ - 1));
    wire enter_set = (state == ST_RUN) && key_star;
    wire commit    = (state == ST_SET) && key_hash;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: if (key_star) state_nxt = ST_SET;
            ST_SET: if (key_star || key_hash) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        setting = (state == ST_SET);
    end

    // A commit coinciding with a tick wins; the tick is lost but still pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q    <= '0;
            div_q     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= tick;
            if (commit) begin
                time_q <= temp_q;
                div_q  <= '0;
            end else if (tick) begin
                time_q <= time_inc(time_q);
                div_q  <= '0;
            end else begin
                div_q  <= div_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        lim = POS_LIMIT[pos];
        if (pos == 3'd1 && temp_q[5] == 4'd2) lim = H_ONE_LIMIT_20;
        digit_ok = setting && key_digit && (keypad_input <= lim);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_q <= '0;
            pos    <= 3'd0;
        end else if (enter_set) begin
            temp_q <= time_q;
            pos    <= 3'd0;
        end else if (digit_ok) begin
            temp_q[pos_idx(pos)] <= keypad_input;
            if (pos == 3'd0 && keypad_input == 4'd2 && temp_q[4] > H_ONE_LIMIT_20)
                temp_q[4] <= 4'd0;
            if (pos != 3'd5) pos <= pos + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            scan_cnt  <= '0;
            scan_idx  <= 3'd0;
        end else begin
            if (enter_set) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign pm = (time_q[5] == 4'd2) || (time_q[5] == 4'd1 && time_q[4] >= 4'd2);

    always_comb begin
        src  = setting ? temp_q : time_q;
        disp = src;
        if (!setting && mode_12h) begin
            if ({src[5], src[4]} == 8'h00) begin
                disp[5] = 4'd1;
                disp[4] = 4'd2;
            end else if ({src[5], src[4]} > 8'h12) begin
                if (src[5] == 4'd1) begin
                    disp[5] = 4'd0;
                    disp[4] = src[4] - 4'd2;
                end else if (src[4] < 4'd2) begin
                    disp[5] = 4'd0;
                    disp[4] = src[4] + 4'd8;
                end else begin
                    disp[5] = 4'd1;
                    disp[4] = src[4] - 4'd2;
                end
            end
            if (disp[5] == 4'd0) disp[5] = BLANK;
        end
        cur_digit = disp[pos_idx(scan_idx)];
        blank_all = setting && (scan_idx == pos) && !blink_on;
        dp        = (scan_idx == 3'd1) || (scan_idx == 3'd3) ||
                    (scan_idx == 3'd5 && pm && mode_12h);
        seg_raw   = blank_all ? 8'h00 : {seg7, dp};
    end

    seg7_decode u_dec (
        .bcd (cur_digit),
        .seg (seg7)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_com  <= COM_OFF;
            seg_data <= SEG_OFF;
        end else begin
            seg_com  <= COM_PAT[scan_idx];
            seg_data <= SEG_ACT_HIGH ? seg_raw : ~seg_raw;
        end
    end

endmodule
